// File: rtl/hwpe_stream_rr_arbiter_if.sv
// rtl/hwpe_stream_rr_arbiter_if.sv - HWPE stream valid/ready handshake bundle
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
    modport master (output valid, data, strb, input ready);
    modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_rr_arbiter.sv
// rtl/hwpe_stream_rr_arbiter.sv - round-robin burst arbiter sharing one stream sink
module hwpe_stream_rr_arbiter #(
    parameter int unsigned NB_IN_STREAMS = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned BURST_WIDTH   = 4,
    localparam int unsigned GRANT_WIDTH  = $clog2(NB_IN_STREAMS),
    localparam int unsigned STRB_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [BURST_WIDTH-1:0] burst_len_i,
    hwpe_stream_intf_stream.sink   push_i [NB_IN_STREAMS],
    hwpe_stream_intf_stream.source pop_o,
    output logic                   grant_valid_o,
    output logic [GRANT_WIDTH-1:0] grant_o
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]             state_q;
    logic [GRANT_WIDTH-1:0] ptr_q;
    logic [GRANT_WIDTH-1:0] grant_q;
    logic [BURST_WIDTH-1:0] cnt_q;
    logic [BURST_WIDTH-1:0] len_q;
    logic                   valid_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [STRB_WIDTH-1:0]  strb_q;

    logic [NB_IN_STREAMS-1:0] in_valid;
    logic [NB_IN_STREAMS-1:0] in_ready;
    logic [DATA_WIDTH-1:0]    in_data [NB_IN_STREAMS];
    logic [STRB_WIDTH-1:0]    in_strb [NB_IN_STREAMS];

    // Interface arrays cannot be indexed by a variable, so flatten them here.
    for (genvar k = 0; k < NB_IN_STREAMS; k++) begin : g_flatten
        assign in_valid[k]    = push_i[k].valid;
        assign in_data[k]     = push_i[k].data;
        assign in_strb[k]     = push_i[k].strb;
        assign push_i[k].ready = in_ready[k];
    end

    logic                   sel_found;
    logic [GRANT_WIDTH-1:0] sel;
    logic [GRANT_WIDTH-1:0] cand;
    int unsigned            idx;

    // First valid requester at or after ptr_q, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        cand      = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NB_IN_STREAMS; i++) begin
            idx  = (32'(ptr_q) + i) % NB_IN_STREAMS;
            cand = idx[GRANT_WIDTH-1:0];
            if (!sel_found && in_valid[cand]) begin
                sel_found = 1'b1;
                sel       = cand;
            end
        end
    end

    logic granted_valid;
    logic granted_ready;
    logic accept;
    logic last_beat;
    logic release_lock;
    logic [GRANT_WIDTH-1:0] next_ptr;

    assign granted_valid = in_valid[grant_q];
    assign granted_ready = (state_q == LOCKED) && (!valid_q || pop_o.ready);
    assign accept        = granted_valid && granted_ready;
    assign last_beat     = (len_q != '0) && (cnt_q == len_q - 1'b1);
    assign release_lock  = (state_q == LOCKED) && (!granted_valid || (accept && last_beat));
    assign next_ptr      = (32'(grant_q) == NB_IN_STREAMS - 1) ? '0 : grant_q + 1'b1;

    always_comb begin
        in_ready = '0;
        in_ready[grant_q] = granted_ready;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else if (clear_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else if (state_q == IDLE) begin
            if (sel_found) begin
                state_q <= LOCKED;
                grant_q <= sel;
                len_q   <= burst_len_i;
                cnt_q   <= '0;
            end
        end else begin
            // Unlimited bursts can outrun the counter; pin it instead of wrapping.
            if (accept && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (release_lock) begin
                state_q <= IDLE;
                ptr_q   <= next_ptr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= in_data[grant_q];
            strb_q  <= in_strb[grant_q];
        end else if (pop_o.ready) begin
            valid_q <= 1'b0;
        end
    end

    assign pop_o.valid   = valid_q;
    assign pop_o.data    = data_q;
    assign pop_o.strb    = strb_q;
    assign grant_valid_o = (state_q == LOCKED);
    assign grant_o       = grant_q;

endmodule
